// File: rtl/snf_read_responder_pkg.sv
// CHI flit types, opcodes and helpers shared by the SN-F read responder and its
// request queue. Node IDs are 7 bits, TxnIDs and DBIDs are 8 bits, and data beats are 128 bits.
package snf_read_responder_pkg;

  localparam int ADDR_W = 48;
  localparam int DATA_W = 128;

  localparam logic [5:0] OP_READ_NO_SNP = 6'h04;
  localparam logic [5:0] OP_READ_UNIQUE = 6'h07;
  localparam logic [3:0] OP_COMP_DATA   = 4'h4;
  localparam logic [2:0] CHI_RESP_UC    = 3'b010;
  localparam logic [2:0] MAX_SIZE       = 3'd6;

  typedef struct packed {
    logic [6:0]        tgt_id;
    logic [6:0]        src_id;
    logic [7:0]        txn_id;
    logic [6:0]        return_nid;
    logic [7:0]        return_txn_id;
    logic [5:0]        opcode;
    logic [2:0]        size;
    logic [ADDR_W-1:0] addr;
  } reqflit_t;

  typedef struct packed {
    logic [6:0]        tgt_id;
    logic [6:0]        src_id;
    logic [7:0]        txn_id;
    logic [6:0]        home_nid;
    logic [3:0]        opcode;
    logic [2:0]        resp;
    logic [7:0]        dbid;
    logic [1:0]        data_id;
    logic [DATA_W-1:0] data;
  } datflit_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [2:0]        size;
    logic [6:0]        return_nid;
    logic [7:0]        return_txn_id;
    logic [6:0]        src_id;
  } queue_entry_t;

  function automatic reqflit_t CreateReadNoSnpReqFlit(
    input logic [6:0]        tgt_id,
    input logic [6:0]        src_id,
    input logic [7:0]        txn_id,
    input logic [6:0]        return_nid,
    input logic [7:0]        return_txn_id,
    input logic [ADDR_W-1:0] addr,
    input logic [2:0]        size
  );
    reqflit_t f;
    f               = '0;
    f.tgt_id        = tgt_id;
    f.src_id        = src_id;
    f.txn_id        = txn_id;
    f.return_nid    = return_nid;
    f.return_txn_id = return_txn_id;
    f.opcode        = OP_READ_NO_SNP;
    f.size          = size;
    f.addr          = addr;
    return f;
  endfunction

  function automatic datflit_t CreateCompDataFlit(
    input logic [6:0]        tgt_id,
    input logic [7:0]        txn_id,
    input logic [6:0]        home_nid,
    input logic [7:0]        dbid,
    input logic [1:0]        data_id,
    input logic [DATA_W-1:0] data
  );
    datflit_t f;
    f          = '0;
    f.tgt_id   = tgt_id;
    f.txn_id   = txn_id;
    f.home_nid = home_nid;
    f.opcode   = OP_COMP_DATA;
    f.resp     = CHI_RESP_UC;
    f.dbid     = dbid;
    f.data_id  = data_id;
    f.data     = data;
    return f;
  endfunction

  // Line index of the first beat: the request is aligned down to its total transfer size.
  function automatic logic [ADDR_W-5:0] base_line(input logic [ADDR_W-1:0] addr,
                                                  input logic [2:0] size);
    logic [ADDR_W-5:0] l;
    l = addr[ADDR_W-1:4];
    if (size == 3'd5)      l[0]   = 1'b0;
    else if (size >= 3'd6) l[1:0] = 2'b00;
    return l;
  endfunction

  function automatic logic [1:0] last_beat(input logic [2:0] size);
    if (size <= 3'd4)      return 2'd0;
    else if (size == 3'd5) return 2'd1;
    else                   return 2'd3;
  endfunction

endpackage

// File: rtl/snf_read_responder_if.sv
// Request, data and preload signals between the home-node side and the SN-F responder.
interface snf_read_responder_if #(parameter int MEM_LINES = 1024);
  import snf_read_responder_pkg::*;

  reqflit_t                       req;
  logic                           req_valid;
  logic                           req_ready;
  datflit_t                       dat;
  logic                           dat_valid;
  logic                           dat_ready;
  logic                           mem_we;
  logic [$clog2(MEM_LINES)-1:0]   mem_waddr;
  logic [DATA_W-1:0]              mem_wdata;
  logic                           err_unsupported;

  modport master (
    output req, req_valid, dat_ready, mem_we, mem_waddr, mem_wdata,
    input  req_ready, dat, dat_valid, err_unsupported
  );

  modport slave (
    input  req, req_valid, dat_ready, mem_we, mem_waddr, mem_wdata,
    output req_ready, dat, dat_valid, err_unsupported
  );
endinterface

// File: rtl/snf_read_responder_req_fifo.sv
// Synchronous FIFO with an extra pointer bit to tell full from empty; the read
// pointer doubles as the index of the head entry.
module req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH)-1:0] rd_idx
);
  localparam int PW = $clog2(DEPTH);

  logic [PW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] entries [DEPTH];

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign dout   = entries[rd_ptr[PW-1:0]];
  assign rd_idx = rd_ptr[PW-1:0];

  // NOTE: registers use non-blocking assignments so every always_ff samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage has no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push && !full) entries[wr_ptr[PW-1:0]] <= din;
  end
endmodule

// File: rtl/snf_read_responder.sv
// SN-F read responder: queues ReadNoSnp requests, reads the local line store and
// returns CompData beats straight to the requester (direct memory transfer).
module snf_read_responder #(
  parameter int DEPTH     = 4,
  parameter int MEM_LINES = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  snf_read_responder_if.slave  bus
);
  import snf_read_responder_pkg::*;

  localparam int AW = $clog2(MEM_LINES);
  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, READ, SEND} state_t;

  state_t            state;
  logic [1:0]        beat;
  datflit_t          dat_q;
  logic              dat_valid_q;
  logic              err_q;

  logic              full, empty, push, bad, fifo_push, pop;
  queue_entry_t      new_entry, head;
  logic [IW-1:0]     head_idx;
  logic [ADDR_W-5:0] base;
  logic [AW-1:0]     rd_line;
  logic [1:0]        data_id;
  logic              is_last;
  logic [DATA_W-1:0] mem [MEM_LINES];
  logic              unused_bits;

  assign bus.req_ready       = ~full;
  assign bus.dat             = dat_q;
  assign bus.dat_valid       = dat_valid_q;
  assign bus.err_unsupported = err_q;

  assign push      = bus.req_valid & ~full;
  assign bad       = (bus.req.opcode != OP_READ_NO_SNP) || (bus.req.size > MAX_SIZE);
  assign fifo_push = push & ~bad;

  assign new_entry.addr          = bus.req.addr;
  assign new_entry.size          = bus.req.size;
  assign new_entry.return_nid    = bus.req.return_nid;
  assign new_entry.return_txn_id = bus.req.return_txn_id;
  assign new_entry.src_id        = bus.req.src_id;

  req_fifo #(
    .WIDTH ($bits(queue_entry_t)),
    .DEPTH (DEPTH)
  ) u_req_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (fifo_push),
    .din    (new_entry),
    .pop    (pop),
    .dout   (head),
    .full   (full),
    .empty  (empty),
    .rd_idx (head_idx)
  );

  // Line and DataID of the current beat, both wrapping naturally in their widths.
  assign base    = base_line(head.addr, head.size);
  assign rd_line = base[AW-1:0] + AW'(beat);
  assign data_id = base[1:0] + beat;
  assign is_last = (beat == last_beat(head.size));
  assign pop     = (state == SEND) && bus.dat_ready && is_last;

  assign unused_bits = ^{base[ADDR_W-5:AW], bus.req.tgt_id, bus.req.txn_id};

  always_ff @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_waddr] <= bus.mem_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      beat        <= '0;
      dat_q       <= '0;
      dat_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= push & bad;
      case (state)
        IDLE: begin
          if (!empty) begin
            beat  <= '0;
            state <= READ;
          end
        end
        READ: begin
          // A preload write to this line in the same cycle is not yet visible here.
          dat_q       <= CreateCompDataFlit(head.return_nid, head.return_txn_id, head.src_id,
                                            8'(head_idx), data_id, mem[rd_line]);
          dat_valid_q <= 1'b1;
          state       <= SEND;
        end
        SEND: begin
          if (bus.dat_ready) begin
            dat_valid_q <= 1'b0;
            if (is_last) begin
              beat  <= '0;
              state <= IDLE;
            end else begin
              beat  <= beat + 2'd1;
              state <= READ;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
